tile_sched: RTL and testbench

- Sequences one convolution layer's input feature map through the compute datapath, one tile at a time.
- Config comes from the dla_ctrl register file: tile length/height per class, tile counts, kernel, stride.
- After a start pulse, walks the tile grid in row-major order and issues one descriptor per tile (origin, size, class) over a valid/ready handshake.
- Waits for the datapath to report tile completion before issuing the next tile; pulses done after the last tile.

---
 rtl/tile_sched.sv | 201 ++++++++++++++++++++
 tb/tb_tile_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sched.sv
// Walks a layer's padded input map tile by tile in row-major order, issuing one
// descriptor per tile and waiting for the datapath to finish it before the next.
//
// state  | meaning
// IDLE   | waiting for start; config inputs latched on start
// CHECK  | validate latched config, seed indices at tile (0,0)
// ISSUE  | descriptor valid, held until tile_ready
// WAIT   | descriptor accepted, waiting for tile_done
// DONE   | one-cycle sched_done pulse
module tile_sched #(
  parameter int CW = 16,
  parameter int DW = 8,
  parameter int NW = 8
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] cfg_kernel,
  input  logic [DW-1:0] cfg_stride,
  input  logic [DW-1:0] cfg_len_full,
  input  logic [DW-1:0] cfg_len_edge,
  input  logic [DW-1:0] cfg_hgt_full,
  input  logic [DW-1:0] cfg_hgt_edge,
  input  logic [NW-1:0] cfg_cols_full,
  input  logic [NW-1:0] cfg_rows_full,
  input  logic          cfg_col_edge,
  input  logic          cfg_row_edge,
  output logic          tile_valid,
  input  logic          tile_ready,
  output logic [CW-1:0] tile_x,
  output logic [CW-1:0] tile_y,
  output logic [DW-1:0] tile_w,
  output logic [DW-1:0] tile_h,
  output logic [1:0]    tile_class,
  output logic          tile_last,
  input  logic          tile_done,
  output logic          busy,
  output logic          sched_done,
  output logic          cfg_err
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic [DW-1:0] k_q, s_q, l0_q, l1_q, h0_q, h1_q;
  logic [NW-1:0] cols_q, rows_q;
  logic          cedge_q, redge_q;
  logic [NW-1:0] col_q, row_q;
  logic [CW-1:0] x_q, y_q;
  logic          valid_q, last_q, busy_q, done_q, err_q;
  logic [DW-1:0] w_q, h_q;
  logic [1:0]    class_q;

  logic [DW-1:0] ovl, step_x, step_y;
  logic          cfg_bad;
  logic [NW-1:0] nxt_col, nxt_row;
  logic [CW-1:0] nxt_x, nxt_y;
  logic [DW-1:0] nxt_w, nxt_h;
  logic [1:0]    nxt_class;
  logic          nxt_last;

  // Compared one bit wider so a full 2^NW-entry axis never wraps.
  function automatic logic at_end(input logic [NW-1:0] idx, input logic [NW-1:0] full,
                                  input logic edge_b);
    return ({1'b0, idx} + (NW+1)'(1)) == ({1'b0, full} + (NW+1)'(edge_b));
  endfunction

  always_comb begin
    ovl     = k_q - s_q;
    step_x  = l0_q - ovl;
    step_y  = h0_q - ovl;
    cfg_bad = (k_q < s_q) || (l0_q <= ovl) || (h0_q <= ovl) ||
              ((cols_q == '0) && !cedge_q) || ((rows_q == '0) && !redge_q);
  end

  // Index/origin of the tile to issue next; CHECK seeds the grid at (0,0).
  always_comb begin
    nxt_col = '0;
    nxt_row = '0;
    nxt_x   = '0;
    nxt_y   = '0;
    if (state_q == S_WAIT) begin
      if (at_end(col_q, cols_q, cedge_q)) begin
        nxt_row = row_q + 1'b1;
        nxt_y   = y_q + CW'(step_y);
      end else begin
        nxt_col = col_q + 1'b1;
        nxt_x   = x_q + CW'(step_x);
        nxt_row = row_q;
        nxt_y   = y_q;
      end
    end
    nxt_w     = (nxt_col < cols_q) ? l0_q : l1_q;
    nxt_h     = (nxt_row < rows_q) ? h0_q : h1_q;
    nxt_class = {nxt_row >= rows_q, nxt_col >= cols_q};
    nxt_last  = at_end(nxt_col, cols_q, cedge_q) && at_end(nxt_row, rows_q, redge_q);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      l0_q    <= '0;
      l1_q    <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
      cedge_q <= 1'b0;
      redge_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      class_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          k_q     <= cfg_kernel;
          s_q     <= cfg_stride;
          l0_q    <= cfg_len_full;
          l1_q    <= cfg_len_edge;
          h0_q    <= cfg_hgt_full;
          h1_q    <= cfg_hgt_edge;
          cols_q  <= cfg_cols_full;
          rows_q  <= cfg_rows_full;
          cedge_q <= cfg_col_edge;
          redge_q <= cfg_row_edge;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (cfg_bad) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            col_q   <= nxt_col;
            row_q   <= nxt_row;
            x_q     <= nxt_x;
            y_q     <= nxt_y;
            w_q     <= nxt_w;
            h_q     <= nxt_h;
            class_q <= nxt_class;
            last_q  <= nxt_last;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: if (tile_ready) begin
          valid_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: if (tile_done) begin
          if (last_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            col_q   <= nxt_col;
            row_q   <= nxt_row;
            x_q     <= nxt_x;
            y_q     <= nxt_y;
            w_q     <= nxt_w;
            h_q     <= nxt_h;
            class_q <= nxt_class;
            last_q  <= nxt_last;
            valid_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tile_valid = valid_q;
  assign tile_x     = x_q;
  assign tile_y     = y_q;
  assign tile_w     = w_q;
  assign tile_h     = h_q;
  assign tile_class = class_q;
  assign tile_last  = last_q;
  assign busy       = busy_q;
  assign sched_done = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_tile_sched.sv
// Bench for tile_sched: directed and random jobs checked against a tile list
// computed directly from the grid geometry.
module tb_tile_sched;
  localparam int CW = 16;
  localparam int DW = 8;
  localparam int NW = 8;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_kernel = '0, cfg_stride = '0, cfg_len_full = '0, cfg_len_edge = '0;
  logic [DW-1:0] cfg_hgt_full = '0, cfg_hgt_edge = '0;
  logic [NW-1:0] cfg_cols_full = '0, cfg_rows_full = '0;
  logic          cfg_col_edge = 1'b0, cfg_row_edge = 1'b0;
  logic          tile_ready = 1'b1;
  logic          tile_done = 1'b0;
  logic          tile_valid, tile_last, busy, sched_done, cfg_err;
  logic [CW-1:0] tile_x, tile_y;
  logic [DW-1:0] tile_w, tile_h;
  logic [1:0]    tile_class;

  tile_sched #(.CW(CW), .DW(DW), .NW(NW)) dut (
    .clock(clock), .rst_n(rst_n), .start(start),
    .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride),
    .cfg_len_full(cfg_len_full), .cfg_len_edge(cfg_len_edge),
    .cfg_hgt_full(cfg_hgt_full), .cfg_hgt_edge(cfg_hgt_edge),
    .cfg_cols_full(cfg_cols_full), .cfg_rows_full(cfg_rows_full),
    .cfg_col_edge(cfg_col_edge), .cfg_row_edge(cfg_row_edge),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_x(tile_x), .tile_y(tile_y), .tile_w(tile_w), .tile_h(tile_h),
    .tile_class(tile_class), .tile_last(tile_last), .tile_done(tile_done),
    .busy(busy), .sched_done(sched_done), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always @(negedge clock) if (sched_done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int x; int y; int w; int h; int cls; int last;
  } tile_t;

  tile_t exp_q[$];
  bit    exp_err;
  int    k, s, l0, l1, h0, h1, cols, rows, ce, re;

  // Reference: tile origins as index * step, mod 2^CW.
  task automatic build_exp();
    int ovl, ncols, nrows;
    tile_t t;
    exp_q.delete();
    ovl     = k - s;
    exp_err = (k < s) || (l0 <= ovl) || (h0 <= ovl) ||
              (cols == 0 && ce == 0) || (rows == 0 && re == 0);
    if (exp_err) return;
    ncols = cols + ce;
    nrows = rows + re;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < ncols; c++) begin
        t.x    = (c * (l0 - ovl)) % (1 << CW);
        t.y    = (r * (h0 - ovl)) % (1 << CW);
        t.w    = (c < cols) ? l0 : l1;
        t.h    = (r < rows) ? h0 : h1;
        t.cls  = ((r >= rows) ? 2 : 0) + ((c >= cols) ? 1 : 0);
        t.last = (r == nrows - 1 && c == ncols - 1) ? 1 : 0;
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic check_tile(input int i, input string nm);
    tile_t t;
    t = exp_q[i];
    check_eq($sformatf("%s t%0d valid", nm, i), tile_valid, 1);
    check_eq($sformatf("%s t%0d x", nm, i), tile_x, t.x);
    check_eq($sformatf("%s t%0d y", nm, i), tile_y, t.y);
    check_eq($sformatf("%s t%0d w", nm, i), tile_w, t.w);
    check_eq($sformatf("%s t%0d h", nm, i), tile_h, t.h);
    check_eq($sformatf("%s t%0d class", nm, i), tile_class, t.cls);
    check_eq($sformatf("%s t%0d last", nm, i), tile_last, t.last);
  endtask

  task automatic run_job(input string nm, input int stall_tile, input int stall_n,
                         input int dly, input int noise_tile, input int abort_tile);
    build_exp();
    done_cnt = 0;
    @(negedge clock);
    cfg_kernel = DW'(k);     cfg_stride = DW'(s);
    cfg_len_full = DW'(l0);  cfg_len_edge = DW'(l1);
    cfg_hgt_full = DW'(h0);  cfg_hgt_edge = DW'(h1);
    cfg_cols_full = NW'(cols); cfg_rows_full = NW'(rows);
    cfg_col_edge = ce[0];    cfg_row_edge = re[0];
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    // Config is latched; later changes must have no effect.
    cfg_kernel = DW'($urandom); cfg_stride = DW'($urandom);
    cfg_len_full = DW'($urandom); cfg_hgt_full = DW'($urandom);
    cfg_cols_full = NW'($urandom); cfg_col_edge = 1'($urandom);
    check_eq({nm, " busy@T+1"}, busy, 1);
    check_eq({nm, " valid@T+1"}, tile_valid, 0);
    check_eq({nm, " err cleared"}, cfg_err, 0);
    @(negedge clock);
    if (exp_err) begin
      check_eq({nm, " err done@T+2"}, sched_done, 1);
      check_eq({nm, " err flag"}, cfg_err, 1);
      check_eq({nm, " err no valid"}, tile_valid, 0);
      @(negedge clock);
      check_eq({nm, " err busy drop"}, busy, 0);
      check_eq({nm, " err done pulse"}, sched_done, 0);
      check_eq({nm, " err sticky"}, cfg_err, 1);
      check_eq({nm, " err no valid2"}, tile_valid, 0);
      check_eq({nm, " err done count"}, done_cnt, 1);
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      check_tile(i, nm);
      check_eq($sformatf("%s t%0d busy", nm, i), busy, 1);
      check_eq($sformatf("%s t%0d nodone", nm, i), sched_done, 0);
      check_eq($sformatf("%s t%0d err", nm, i), cfg_err, 0);
      if (i == stall_tile) begin
        tile_ready = 1'b0;
        for (int j = 0; j < stall_n; j++) begin
          if (j == 0) begin tile_done = 1'b1; start = 1'b1; end
          @(negedge clock);
          tile_done = 1'b0;
          start = 1'b0;
          check_tile(i, {nm, " stall"});
        end
        tile_ready = 1'b1;
      end
      @(negedge clock);
      check_eq($sformatf("%s t%0d accepted", nm, i), tile_valid, 0);
      if (i == abort_tile) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq({nm, " rst valid"}, tile_valid, 0);
        check_eq({nm, " rst busy"}, busy, 0);
        check_eq({nm, " rst xy"}, {tile_x, tile_y}, 0);
        check_eq({nm, " rst wh"}, {tile_w, tile_h}, 0);
        check_eq({nm, " rst misc"}, {tile_class, tile_last, sched_done, cfg_err}, 0);
        @(negedge clock);
        rst_n = 1'b1;
        return;
      end
      start = (i == noise_tile);
      for (int j = 0; j < dly; j++) begin
        @(negedge clock);
        start = 1'b0;
        check_eq($sformatf("%s t%0d wait", nm, i), tile_valid, 0);
      end
      tile_done = 1'b1;
      @(negedge clock);
      tile_done = 1'b0;
      start = 1'b0;
    end
    check_eq({nm, " done pulse"}, sched_done, 1);
    check_eq({nm, " done busy"}, busy, 1);
    check_eq({nm, " done novalid"}, tile_valid, 0);
    @(negedge clock);
    check_eq({nm, " done drop"}, sched_done, 0);
    check_eq({nm, " busy drop"}, busy, 0);
    check_eq({nm, " done count"}, done_cnt, 1);
  endtask

  task automatic main_cfg();
    k = 3; s = 1; l0 = 32; l1 = 24; h0 = 32; h1 = 24;
    cols = 3; rows = 3; ce = 1; re = 1;
  endtask

  initial begin
    #1;
    check_eq("reset valid", tile_valid, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset outs", {tile_x, tile_y, tile_w, tile_h, tile_class, tile_last,
                            sched_done, cfg_err}, 0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    main_cfg();
    run_job("main", 1, 5, 1, 6, -1);

    k = 1; s = 2;
    run_job("k<s", -1, 0, 1, -1, -1);

    main_cfg(); cols = 0; ce = 0;
    run_job("nocols", -1, 0, 1, -1, -1);

    main_cfg(); cols = 0; ce = 1; rows = 0; re = 1; l1 = 20; h1 = 18;
    run_job("single", -1, 0, 1, -1, -1);

    main_cfg();
    run_job("abort", -1, 0, 1, -1, 4);
    main_cfg();
    run_job("rerun", -1, 0, 1, -1, -1);

    k = 1; s = 1; l0 = 255; l1 = 7; h0 = 9; h1 = 5;
    cols = 255; rows = 0; ce = 1; re = 1;
    run_job("maxcol", 100, 2, 0, -1, -1);

    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(1, 6); s = $urandom_range(1, 6);
      l0 = $urandom_range(1, 40); l1 = $urandom_range(1, 255);
      h0 = $urandom_range(1, 40); h1 = $urandom_range(1, 255);
      cols = $urandom_range(0, 4); rows = $urandom_range(0, 4);
      ce = $urandom_range(0, 1); re = $urandom_range(0, 1);
      run_job($sformatf("rnd%0d", n), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 6), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
